// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC owner: sequential advance, hazard freeze, taken-branch redirect with
// a one-cycle wrong-path flush, JAL link capture and a saturating redirect counter.
module pc_redirect_unit #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brCond,
    input  logic [1:0]          brKind,
    input  logic [WORD_LEN-1:0] brTarget,
    input  logic [WORD_LEN-1:0] jrReg,
    input  logic [WORD_LEN-1:0] idPcPlus1,
    output logic [WORD_LEN-1:0] pc,
    output logic [WORD_LEN-1:0] pcPlus1,
    output logic                flush,
    output logic [WORD_LEN-1:0] linkAddr,
    output logic                linkValid,
    output logic [CNT_W-1:0]    takenCount
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [WORD_LEN-1:0] PC_ONE  = {{(WORD_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]          KIND_JAL = 2'b01;
    localparam logic [1:0]          KIND_JR  = 2'b10;

    state_t                state_q, state_d;
    logic [WORD_LEN-1:0]   pc_q, pc_d;
    logic                  flush_q, flush_d;
    logic [WORD_LEN-1:0]   link_addr_q, link_addr_d;
    logic                  link_valid_q, link_valid_d;
    logic [CNT_W-1:0]      taken_count_q, taken_count_d;

    logic                  accept_s;
    logic [WORD_LEN-1:0]   target_s;
    logic [WORD_LEN-1:0]   pc_plus1_s;

    // The ID instruction is wrong-path while flushing, so its decision is never accepted then.
    assign accept_s   = (state_q == RUN) && !freeze && brCond;
    assign target_s   = (brKind == KIND_JR) ? jrReg : brTarget;
    assign pc_plus1_s = pc_q + PC_ONE;

    // State register: every flop of the block, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            flush_q       <= 1'b0;
            link_addr_q   <= '0;
            link_valid_q  <= 1'b0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            link_addr_q   <= link_addr_d;
            link_valid_q  <= link_valid_d;
            taken_count_q <= taken_count_d;
        end
    end

    // Next-state logic: FLUSH always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (accept_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output/datapath logic: PC selection, flush, link capture and counter.
    always_comb begin
        pc_d          = pc_q;
        flush_d       = 1'b0;
        link_addr_d   = link_addr_q;
        link_valid_d  = 1'b0;
        taken_count_d = taken_count_q;
        if (accept_s) begin
            pc_d    = target_s;
            flush_d = 1'b1;
            if (brKind == KIND_JAL) begin
                link_addr_d  = idPcPlus1;
                link_valid_d = 1'b1;
            end else begin
                link_valid_d = 1'b0;
            end
            if (taken_count_q != CNT_MAX) begin
                taken_count_d = taken_count_q + CNT_ONE;
            end else begin
                taken_count_d = taken_count_q;
            end
        end else if (freeze) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus1_s;
        end
    end

    assign pc         = pc_q;
    assign pcPlus1    = pc_plus1_s;
    assign flush      = flush_q;
    assign linkAddr   = link_addr_q;
    assign linkValid  = link_valid_q;
    assign takenCount = taken_count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: each scenario pushes the expected post-edge
// observation when it drives a cycle, then pops and compares after the edge.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        brCond = 1'b0;
    logic [1:0]  brKind = 2'b00;
    logic [31:0] brTarget = 32'h0;
    logic [31:0] jrReg = 32'h0;
    logic [31:0] idPcPlus1 = 32'h0;
    logic [31:0] pc, pcPlus1, linkAddr;
    logic        flush, linkValid;
    logic [15:0] takenCount;
    logic [31:0] pc2, pcPlus12, linkAddr2;
    logic        flush2, linkValid2;
    logic [1:0]  takenCount2;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pp;
        logic        fl;
        logic        lv;
        logic [31:0] la;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        fr;
        logic        bc;
        logic [1:0]  bk;
        logic [31:0] bt;
        logic [31:0] jr;
        logic [31:0] idp;
    } stim_t;

    obs_t       sb[$];
    logic [1:0] sb_cnt[$];

    pc_redirect_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .brCond(brCond), .brKind(brKind),
        .brTarget(brTarget), .jrReg(jrReg), .idPcPlus1(idPcPlus1),
        .pc(pc), .pcPlus1(pcPlus1), .flush(flush), .linkAddr(linkAddr),
        .linkValid(linkValid), .takenCount(takenCount)
    );

    pc_redirect_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .brCond(brCond), .brKind(brKind),
        .brTarget(brTarget), .jrReg(jrReg), .idPcPlus1(idPcPlus1),
        .pc(pc2), .pcPlus1(pcPlus12), .flush(flush2), .linkAddr(linkAddr2),
        .linkValid(linkValid2), .takenCount(takenCount2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        return '{pc: pc, pp: pcPlus1, fl: flush, lv: linkValid, la: linkAddr, cnt: takenCount};
    endfunction

    function automatic obs_t mk(input logic [31:0] p, input logic f, input logic lv,
                                input logic [31:0] la, input logic [15:0] c);
        return '{pc: p, pp: p + 32'd1, fl: f, lv: lv, la: la, cnt: c};
    endfunction

    function automatic stim_t idle();
        return '{fr: 1'b0, bc: 1'b0, bk: 2'b00, bt: 32'h0, jr: 32'h0, idp: 32'h0};
    endfunction

    function automatic stim_t br(input logic [1:0] k, input logic [31:0] t,
                                 input logic [31:0] j, input logic [31:0] i);
        return '{fr: 1'b0, bc: 1'b1, bk: k, bt: t, jr: j, idp: i};
    endfunction

    // Drive one cycle of inputs, then return #1 after the rising edge.
    task automatic tick(input stim_t s);
        freeze = s.fr; brCond = s.bc; brKind = s.bk;
        brTarget = s.bt; jrReg = s.jr; idPcPlus1 = s.idp;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick(idle());
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Run a table of stimulus/expectation pairs through the scoreboard.
    task automatic run_steps(input string name, input stim_t st[], input obs_t ex[]);
        obs_t e, g;
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            g = observe();
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL %s step %0d: got pc=%h pp=%h fl=%b lv=%b la=%h cnt=%0d required pc=%h pp=%h fl=%b lv=%b la=%h cnt=%0d",
                         name, i, g.pc, g.pp, g.fl, g.lv, g.la, g.cnt, e.pc, e.pp, e.fl, e.lv, e.la, e.cnt);
            end
        end
    endtask

    task automatic test_reset();
        obs_t e, g;
        stim_t st[3];
        obs_t  ex[3];
        tick(idle());
        rst = 1'b1;
        #1;
        sb.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
        e = sb.pop_front();
        g = observe();
        tests++;
        if (g !== e) begin
            failed++;
            $display("FAIL reset_state: got pc=%h fl=%b cnt=%0d required pc=%h fl=%b cnt=%0d",
                     g.pc, g.fl, g.cnt, e.pc, e.fl, e.cnt);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = idle();
            ex[i] = mk(32'(i + 1), 1'b0, 1'b0, 32'h0, 16'd0);
        end
        run_steps("reset_idle", st, ex);
    endtask

    task automatic test_cond_branch();
        stim_t st[7];
        obs_t  ex[7];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            st[i] = idle();
            ex[i] = mk(32'(i + 1), 1'b0, 1'b0, 32'h0, 16'd0);
        end
        st[4] = idle();                             ex[4] = mk(32'h5,  1'b0, 1'b0, 32'h0, 16'd0);
        st[5] = br(2'b00, 32'h40, 32'h0, 32'h6);    ex[5] = mk(32'h40, 1'b1, 1'b0, 32'h0, 16'd1);
        st[6] = idle();                             ex[6] = mk(32'h41, 1'b0, 1'b0, 32'h0, 16'd1);
        run_steps("cond_branch", st, ex);
    endtask

    task automatic test_jal();
        stim_t st[13];
        obs_t  ex[13];
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            st[i] = idle();
            ex[i] = mk(32'(i + 1), 1'b0, 1'b0, 32'h0, 16'd0);
        end
        st[9]  = br(2'b01, 32'h100, 32'h0, 32'h9);  ex[9]  = mk(32'h100, 1'b1, 1'b1, 32'h9, 16'd1);
        st[10] = idle();                            ex[10] = mk(32'h101, 1'b0, 1'b0, 32'h9, 16'd1);
        st[11] = idle();                            ex[11] = mk(32'h102, 1'b0, 1'b0, 32'h9, 16'd1);
        st[12] = idle();                            ex[12] = mk(32'h103, 1'b0, 1'b0, 32'h9, 16'd1);
        run_steps("jal_link", st, ex);
    endtask

    task automatic test_back_to_back();
        stim_t st[3];
        obs_t  ex[3];
        apply_reset();
        st[0] = br(2'b10, 32'h99, 32'h22, 32'h1);   ex[0] = mk(32'h22, 1'b1, 1'b0, 32'h0, 16'd1);
        st[1] = br(2'b10, 32'h99, 32'h22, 32'h1);   ex[1] = mk(32'h23, 1'b0, 1'b0, 32'h0, 16'd1);
        st[2] = idle();                             ex[2] = mk(32'h24, 1'b0, 1'b0, 32'h0, 16'd1);
        run_steps("jr_back_to_back", st, ex);
    endtask

    task automatic test_freeze();
        stim_t st[12];
        obs_t  ex[12];
        stim_t fz;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            st[i] = idle();
            ex[i] = mk(32'(i + 1), 1'b0, 1'b0, 32'h0, 16'd0);
        end
        fz = br(2'b00, 32'h10, 32'h0, 32'h8);
        fz.fr = 1'b1;
        st[7]  = fz;                                ex[7]  = mk(32'h7,  1'b0, 1'b0, 32'h0, 16'd0);
        st[8]  = fz;                                ex[8]  = mk(32'h7,  1'b0, 1'b0, 32'h0, 16'd0);
        st[9]  = br(2'b00, 32'h10, 32'h0, 32'h8);   ex[9]  = mk(32'h10, 1'b1, 1'b0, 32'h0, 16'd1);
        st[10] = fz;                                ex[10] = mk(32'h10, 1'b0, 1'b0, 32'h0, 16'd1);
        st[11] = idle();                            ex[11] = mk(32'h11, 1'b0, 1'b0, 32'h0, 16'd1);
        run_steps("freeze", st, ex);
    endtask

    task automatic test_saturate();
        logic [1:0] e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            sb_cnt.push_back((i < 3) ? 2'(i + 1) : 2'd3);
            tick(br(2'b00, 32'(16 * (i + 1)), 32'h0, 32'h0));
            tick(idle());
            e = sb_cnt.pop_front();
            tests++;
            if (takenCount2 !== e) begin
                failed++;
                $display("FAIL saturate redirect %0d: got count=%0d required %0d", i + 1, takenCount2, e);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t  e, g;
        stim_t st[1];
        obs_t  ex[1];
        apply_reset();
        st[0] = br(2'b00, 32'h40, 32'h0, 32'h0);    ex[0] = mk(32'h40, 1'b1, 1'b0, 32'h0, 16'd1);
        run_steps("pre_flush", st, ex);
        brCond = 1'b0;
        rst = 1'b1;
        #1;
        sb.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0, 16'd0));
        e = sb.pop_front();
        g = observe();
        tests++;
        if (g !== e) begin
            failed++;
            $display("FAIL reset_mid_flush: got pc=%h fl=%b cnt=%0d required pc=%h fl=%b cnt=%0d",
                     g.pc, g.fl, g.cnt, e.pc, e.fl, e.cnt);
        end
        #1;
        rst = 1'b0;
        st[0] = idle();                             ex[0] = mk(32'h1, 1'b0, 1'b0, 32'h0, 16'd0);
        run_steps("after_abort", st, ex);
    endtask

    task automatic test_wrap();
        stim_t st[2];
        obs_t  ex[2];
        apply_reset();
        st[0] = br(2'b11, 32'hFFFF_FFFF, 32'h0, 32'h0); ex[0] = mk(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 16'd1);
        st[1] = idle();                                 ex[1] = mk(32'h0, 1'b0, 1'b0, 32'h0, 16'd1);
        run_steps("pc_wrap", st, ex);
    endtask

    initial begin
        test_reset();
        test_cond_branch();
        test_jal();
        test_back_to_back();
        test_freeze();
        test_saturate();
        test_reset_mid_flush();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
